// File: rtl/onetofour_tdm_demux_pkg.sv
// Shared definitions for the 4-channel TDM receive demultiplexer.
package onetofour_tdm_demux_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_A = 2'd0;
  localparam slot_t SLOT_B = 2'd1;
  localparam slot_t SLOT_C = 2'd2;
  localparam slot_t SLOT_D = 2'd3;

endpackage

// File: rtl/onetofour_tdm_demux_slot_counter.sv
// Slot position counter: clear to slot A, load to slot B, or advance with wrap.
module tdm_slot_counter
  import onetofour_tdm_demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot
);

  // Load wins over increment: a marker always restarts the frame at slot B.
  always_ff @(posedge clk) begin
    if (rst || clr)  slot <= SLOT_A;
    else if (load1)  slot <= SLOT_B;
    else if (inc)    slot <= slot + 2'd1;
  end

endmodule

// File: rtl/onetofour_tdm_demux.sv
// TDM receive demux: aligns on SYNC, collects four slot samples, and
// publishes A..D together once per complete frame.
module onetofour_tdm_demux
  import onetofour_tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SYNC,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             FRAME_VALID,
  output logic             SYNC_ERR,
  output logic             LOCKED,
  output logic [1:0]       SLOT
);

  state_e state, state_d;
  slot_t  slot;

  // Slot D is never shadowed; it goes straight from DIN to D.
  logic [NUM_CH-2:0][WIDTH-1:0] shadow;
  logic [NUM_CH-2:0]            cap_vec;

  logic cap0, cap_mid, out_upd, err, cnt_clr, cnt_load, cnt_inc;

  tdm_slot_counter u_slot_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .slot  (slot)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_HUNT;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (EN) begin
      unique case (state)
        ST_HUNT:   if (SYNC) state_d = ST_LOCKED;
        ST_LOCKED: if (slot == SLOT_A && !SYNC) state_d = ST_HUNT;
        default:   state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    cap0     = 1'b0;
    cap_mid  = 1'b0;
    out_upd  = 1'b0;
    err      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    if (EN) begin
      unique case (state)
        ST_HUNT: begin
          if (SYNC) begin
            cap0     = 1'b1;
            cnt_load = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (slot == SLOT_A) begin
            if (SYNC) begin
              cap0     = 1'b1;
              cnt_load = 1'b1;
            end else begin
              err     = 1'b1;
              cnt_clr = 1'b1;
            end
          end else if (SYNC) begin
            // Early marker: drop the partial frame and restart on this sample.
            err      = 1'b1;
            cap0     = 1'b1;
            cnt_load = 1'b1;
          end else if (slot == SLOT_D) begin
            out_upd = 1'b1;
            cnt_inc = 1'b1;
          end else begin
            cap_mid = 1'b1;
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cap_vec    = '0;
    cap_vec[0] = cap0;
    for (int k = 1; k < NUM_CH - 1; k++)
      cap_vec[k] = cap_mid && (slot == 2'(k));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow      <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      FRAME_VALID <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      FRAME_VALID <= out_upd;
      SYNC_ERR    <= err;
      for (int k = 0; k < NUM_CH - 1; k++)
        if (cap_vec[k]) shadow[k] <= DIN;
      if (out_upd) begin
        A <= shadow[0];
        B <= shadow[1];
        C <= shadow[2];
        D <= DIN;
      end
    end
  end

  assign LOCKED = (state == ST_LOCKED);
  assign SLOT   = slot;

endmodule
